vc_input_demux: RTL and testbench
=================================

Name: vc_input_demux

Overview:
- Receive end of the per-VC link protocol: accepts one flit per cycle tagged with a virtual-channel id and steers it into one of three per-VC FIFOs.
- Presents each VC's head flit to the router's routing/switch stage.
- Returns one credit pulse upstream per flit dequeued, so the transmitter's per-VC credit counters track free slots here.

Parameters:
- FLIT_W, 35, flit width in bits (data plus type bits).
- DEPTH, 4, entries per VC FIFO; power of two, ≥2.
- PTR_W, 2, log2(DEPTH).
- VCH_W, 2, width of VC id field.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_  in  1  reset; synchronous, active-low.
- ivalid  in  1  flit present on idata this cycle.
- idata  in  FLIT_W  incoming flit.
- ivch  in  VCH_W  target VC id; legal values 0..2.
- ideq  in  3  per-VC dequeue strobe from the switch stage; bit v pops VC v head.
- ovalid0/ovalid1/ovalid2  out  1  VC v FIFO non-empty.
- odata0/odata1/odata2  out  FLIT_W  VC v head flit; all-zero when ovalid_v=0.
- ocredit  out  3  per-VC credit return; 1-cycle pulse per accepted dequeue.
- ocount0/ocount1/ocount2  out  PTR_W+1  VC v occupancy 0..DEPTH.
- oerr  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_=0 at posedge): all write/read pointers and counts go to 0. Outputs: ovalid*=0, odata*=0, ocredit=0, ocount*=0, oerr=0. FIFO contents are discarded. Reset mid-traffic drops all buffered flits; the upstream credit counters are reset by the same rst_.
- Enqueue: on posedge with ivalid=1, ivch=v∈{0,1,2} and VC v not full, idata is written at wptr_v, wptr_v increments modulo DEPTH and count_v increments.
- Illegal VC: ivalid=1 with ivch=3 drops the flit and sets oerr. No FIFO changes.
- Overflow: ivalid=1 to a full VC with no same-cycle dequeue of that VC drops the flit and sets oerr. This is a credit violation upstream.
- Full plus same-cycle dequeue on the same VC: the enqueue is accepted, count is unchanged, and no error is raised.
- Dequeue: ideq[v]=1 with count_v>0 advances rptr_v modulo DEPTH and decrements count_v. ideq[v]=1 on an empty VC is ignored: no credit, no error.
- Enqueue and dequeue on the same non-empty VC in one cycle: count is unchanged and both pointers advance.
- No bypass: a flit written into an empty VC appears on ovalid_v/odata_v the cycle after the write edge (1-cycle latency). An empty VC with simultaneous enq+deq ignores the deq.
- Heads are combinational from the registered FIFO state (mem[rptr_v] gated by count_v≠0).
- ocredit[v] is registered: it is high for exactly the cycle after each posedge where a dequeue of VC v was accepted. Dequeues on consecutive cycles give back-to-back pulses. Multiple VCs may pulse in the same cycle.
- VCs are independent: traffic or an error on one VC never alters the state of another.
- oerr clears only on reset.
- Pointer wrap: pointers are PTR_W bits and wrap naturally at DEPTH. Full is count==DEPTH and empty is count==0; pointer equality is never used to decide full/empty.

Test Plan:
- Reset and single flit: hold rst_=0 for 2 cycles, then write idata=0x1_2345_6789 to VC1 → ovalid1=1 and odata1=0x1_2345_6789 the next cycle, ocount1=1. VC0 and VC2 remain ovalid=0, odata=0.
- Fill and overflow: write 4 flits to VC0 (count 4), then a 5th with no deq → the 5th is dropped, oerr=1, ocount0=4. Then pop 4 → the flits emerge in order, with 4 ocredit[0] pulses on consecutive cycles.
- Full with simultaneous enq/deq: with VC2 full (values A,B,C,D), write E while ideq[2]=1 → oerr stays 0, ocount2=4, head becomes B. Draining yields B,C,D,E.
- Wrap-around: stream 10 flits through VC1 with enq and deq every cycle after the first → the output sequence matches the input, pointers wrap twice, and 10 credits are returned.
- Illegal and empty events: ivch=3 with ivalid=1 → oerr=1, no count changes. ideq=3'b111 with all VCs empty → ocredit stays 0.
- Reset mid-operation: with ocount0=3 and ocount2=2, assert rst_=0 for 1 cycle → all ovalid=0, ocount=0, oerr=0, and no ocredit pulses the following cycle.

Source files
------------

// File: rtl/vc_input_demux.sv
// Receive side of the per-VC link: steers each incoming flit into one of three
// per-VC FIFOs, presents the FIFO heads, and returns one credit per dequeue.
module vc_input_demux #(
  parameter int FLIT_W = 35,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int VCH_W  = 2
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              ivalid,
  input  logic [FLIT_W-1:0] idata,
  input  logic [VCH_W-1:0]  ivch,
  input  logic [2:0]        ideq,
  output logic              ovalid0,
  output logic              ovalid1,
  output logic              ovalid2,
  output logic [FLIT_W-1:0] odata0,
  output logic [FLIT_W-1:0] odata1,
  output logic [FLIT_W-1:0] odata2,
  output logic [2:0]        ocredit,
  output logic [PTR_W:0]    ocount0,
  output logic [PTR_W:0]    ocount1,
  output logic [PTR_W:0]    ocount2,
  output logic              oerr
);

  localparam int NVC = 3;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [NVC-1:0]             deq_ok;
  logic [NVC-1:0]             enq_ok;
  logic [NVC-1:0]             ovf;
  logic [NVC-1:0][FLIT_W-1:0] head;
  logic [NVC-1:0][PTR_W:0]    count;
  logic                       illegal;

  assign illegal = ivalid && (ivch >= VCH_W'(NVC));

  for (genvar v = 0; v < NVC; v++) begin : g_vc
    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [PTR_W:0]    cnt;
    logic              enq_req;

    assign enq_req   = ivalid && (ivch == VCH_W'(v));
    assign deq_ok[v] = ideq[v] && (cnt != '0);
    // A full VC still accepts when its head leaves in the same cycle.
    assign enq_ok[v] = enq_req && ((cnt != FULL_CNT) || deq_ok[v]);
    assign ovf[v]    = enq_req && !enq_ok[v];

    always_ff @(posedge clk) begin
      if (enq_ok[v]) mem[wptr] <= idata;
    end

    always_ff @(posedge clk) begin
      if (!rst_) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (enq_ok[v]) wptr <= wptr + 1'b1;
        if (deq_ok[v]) rptr <= rptr + 1'b1;
        case ({enq_ok[v], deq_ok[v]})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    assign head[v]  = (cnt != '0) ? mem[rptr] : '0;
    assign count[v] = cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      ocredit <= '0;
      oerr    <= 1'b0;
    end else begin
      ocredit <= deq_ok;
      oerr    <= oerr | illegal | (|ovf);
    end
  end

  assign ovalid0 = (count[0] != '0);
  assign ovalid1 = (count[1] != '0);
  assign ovalid2 = (count[2] != '0);
  assign odata0  = head[0];
  assign odata1  = head[1];
  assign odata2  = head[2];
  assign ocount0 = count[0];
  assign ocount1 = count[1];
  assign ocount2 = count[2];

endmodule

// File: tb/tb_vc_input_demux.sv
// Bench for vc_input_demux: directed scenarios plus randomized traffic, all
// checked against a queue-based model of the three VC buffers.
module tb_vc_input_demux;
  localparam int FLIT_W = 35;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = 2;
  localparam int VCH_W  = 2;

  logic              clk = 1'b0;
  logic              rst_ = 1'b0;
  logic              ivalid = 1'b0;
  logic [FLIT_W-1:0] idata = '0;
  logic [VCH_W-1:0]  ivch = '0;
  logic [2:0]        ideq = '0;
  logic              ovalid0, ovalid1, ovalid2;
  logic [FLIT_W-1:0] odata0, odata1, odata2;
  logic [2:0]        ocredit;
  logic [PTR_W:0]    ocount0, ocount1, ocount2;
  logic              oerr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [FLIT_W-1:0] mq [3][$];
  logic [2:0]        exp_credit = '0;
  logic              exp_err = 1'b0;

  logic              ov [3];
  logic [FLIT_W-1:0] od [3];
  logic [PTR_W:0]    oc [3];

  assign ov[0] = ovalid0; assign ov[1] = ovalid1; assign ov[2] = ovalid2;
  assign od[0] = odata0;  assign od[1] = odata1;  assign od[2] = odata2;
  assign oc[0] = ocount0; assign oc[1] = ocount1; assign oc[2] = ocount2;

  always #5 clk = ~clk;

  vc_input_demux #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .PTR_W(PTR_W), .VCH_W(VCH_W)) dut (
    .clk(clk), .rst_(rst_), .ivalid(ivalid), .idata(idata), .ivch(ivch), .ideq(ideq),
    .ovalid0(ovalid0), .ovalid1(ovalid1), .ovalid2(ovalid2),
    .odata0(odata0), .odata1(odata1), .odata2(odata2),
    .ocredit(ocredit), .ocount0(ocount0), .ocount1(ocount1), .ocount2(ocount2),
    .oerr(oerr)
  );

  // One clock cycle: drive inputs, let the edge happen, advance the model by the
  // protocol rules, then settle so outputs can be sampled away from the edge.
  task automatic step(input bit r, input bit iv, input logic [VCH_W-1:0] ch,
                      input logic [FLIT_W-1:0] d, input logic [2:0] dq);
    bit deq [3];
    bit acc [3];
    rst_ = r; ivalid = iv; ivch = ch; idata = d; ideq = dq;
    @(posedge clk);
    if (!r) begin
      for (int v = 0; v < 3; v++) mq[v].delete();
      exp_credit = '0;
      exp_err    = 1'b0;
    end else begin
      for (int v = 0; v < 3; v++) begin
        deq[v] = dq[v] && (mq[v].size() > 0);
        acc[v] = iv && (int'(ch) == v) && (mq[v].size() < DEPTH || deq[v]);
        if (iv && (int'(ch) == v) && !acc[v]) exp_err = 1'b1;
      end
      if (iv && ch == 2'd3) exp_err = 1'b1;
      for (int v = 0; v < 3; v++) begin
        if (deq[v]) void'(mq[v].pop_front());
        if (acc[v]) mq[v].push_back(d);
        exp_credit[v] = deq[v];
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, '0, 3'b000);
  endtask

  task automatic test_reset();
    logic [FLIT_W-1:0] val;
    val = 35'h1_2345_6789;
    step(1'b0, 1'b0, '0, '0, 3'b000);
    step(1'b0, 1'b0, '0, '0, 3'b000);
    for (int v = 0; v < 3; v++) begin
      n_checks++;
      if (ov[v] !== 1'b0 || od[v] !== '0 || oc[v] !== '0) begin
        n_fail++;
        $display("FAIL reset_vc%0d: got valid=%b data=%h count=%0d, want 0/0/0", v, ov[v], od[v], oc[v]);
      end
    end
    n_checks++;
    if (ocredit !== 3'b000 || oerr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got credit=%b err=%b, want 000/0", ocredit, oerr);
    end
    step(1'b1, 1'b1, 2'd1, val, 3'b000);
    n_checks++;
    if (ovalid1 !== 1'b1 || odata1 !== val || ocount1 !== 3'd1) begin
      n_fail++;
      $display("FAIL single_flit: got valid=%b data=%h count=%0d, want 1/%h/1", ovalid1, odata1, ocount1, val);
    end
    n_checks++;
    if (ovalid0 !== 1'b0 || odata0 !== '0 || ovalid2 !== 1'b0 || odata2 !== '0) begin
      n_fail++;
      $display("FAIL single_flit_others: got v0=%b d0=%h v2=%b d2=%h, want all 0", ovalid0, odata0, ovalid2, odata2);
    end
  endtask

  task automatic test_fill_overflow();
    logic [FLIT_W-1:0] vals [4];
    step(1'b0, 1'b0, '0, '0, 3'b000);
    for (int i = 0; i < 4; i++) begin
      vals[i] = {$urandom_range(7, 0), $urandom()};
      step(1'b1, 1'b1, 2'd0, vals[i], 3'b000);
    end
    n_checks++;
    if (ocount0 !== 3'd4 || oerr !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_vc0: got count=%0d err=%b, want 4/0", ocount0, oerr);
    end
    step(1'b1, 1'b1, 2'd0, 35'h7_DEAD_BEEF, 3'b000);
    n_checks++;
    if (ocount0 !== 3'd4 || oerr !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_vc0: got count=%0d err=%b, want 4/1", ocount0, oerr);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (odata0 !== vals[i]) begin
        n_fail++;
        $display("FAIL drain_vc0_order[%0d]: got %h, want %h", i, odata0, vals[i]);
      end
      step(1'b1, 1'b0, '0, '0, 3'b001);
      n_checks++;
      if (ocredit !== 3'b001 || ocount0 !== 3'(3 - i)) begin
        n_fail++;
        $display("FAIL drain_vc0_credit[%0d]: got credit=%b count=%0d, want 001/%0d", i, ocredit, ocount0, 3 - i);
      end
    end
    idle();
    n_checks++;
    if (ocredit !== 3'b000 || ovalid0 !== 1'b0 || odata0 !== '0) begin
      n_fail++;
      $display("FAIL drain_vc0_end: got credit=%b valid=%b data=%h, want 000/0/0", ocredit, ovalid0, odata0);
    end
  endtask

  task automatic test_full_enq_deq();
    logic [FLIT_W-1:0] vals [5];
    step(1'b0, 1'b0, '0, '0, 3'b000);
    for (int i = 0; i < 5; i++) vals[i] = 35'h0_AAAA_0000 + 35'(i);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'd2, vals[i], 3'b000);
    step(1'b1, 1'b1, 2'd2, vals[4], 3'b100);
    n_checks++;
    if (oerr !== 1'b0 || ocount2 !== 3'd4 || odata2 !== vals[1] || ocredit !== 3'b100) begin
      n_fail++;
      $display("FAIL full_enq_deq: got err=%b count=%0d head=%h credit=%b, want 0/4/%h/100",
               oerr, ocount2, odata2, ocredit, vals[1]);
    end
    for (int i = 1; i < 5; i++) begin
      n_checks++;
      if (odata2 !== vals[i]) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: got %h, want %h", i, odata2, vals[i]);
      end
      step(1'b1, 1'b0, '0, '0, 3'b100);
    end
    n_checks++;
    if (ocount2 !== 3'd0 || ovalid2 !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain_end: got count=%0d valid=%b, want 0/0", ocount2, ovalid2);
    end
  endtask

  task automatic test_wrap();
    logic [FLIT_W-1:0] vals [10];
    int credits;
    int outs;
    step(1'b0, 1'b0, '0, '0, 3'b000);
    credits = 0;
    outs = 0;
    for (int i = 0; i < 10; i++) vals[i] = {$urandom_range(7, 0), $urandom()};
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        n_checks++;
        if (ovalid1 !== 1'b1 || odata1 !== vals[outs]) begin
          n_fail++;
          $display("FAIL wrap_head[%0d]: got valid=%b data=%h, want 1/%h", outs, ovalid1, odata1, vals[outs]);
        end
        outs++;
      end
      step(1'b1, (i < 10), 2'd1, (i < 10) ? vals[i] : '0, (i > 0) ? 3'b010 : 3'b000);
      if (ocredit[1]) credits++;
      n_checks++;
      if (ocount1 !== ((i < 10) ? 3'd1 : 3'd0) || oerr !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_count[%0d]: got count=%0d err=%b, want %0d/0", i, ocount1, oerr, (i < 10) ? 1 : 0);
      end
    end
    n_checks++;
    if (credits != 10 || outs != 10) begin
      n_fail++;
      $display("FAIL wrap_credits: got credits=%0d outputs=%0d, want 10/10", credits, outs);
    end
  endtask

  task automatic test_illegal_empty();
    step(1'b0, 1'b0, '0, '0, 3'b000);
    step(1'b1, 1'b0, '0, '0, 3'b111);
    n_checks++;
    if (ocredit !== 3'b000 || oerr !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_deq: got credit=%b err=%b, want 000/0", ocredit, oerr);
    end
    step(1'b1, 1'b1, 2'd3, 35'h5_5555_5555, 3'b000);
    n_checks++;
    if (oerr !== 1'b1 || ocount0 !== '0 || ocount1 !== '0 || ocount2 !== '0) begin
      n_fail++;
      $display("FAIL illegal_vc: got err=%b counts=%0d/%0d/%0d, want 1/0/0/0", oerr, ocount0, ocount1, ocount2);
    end
    idle();
    idle();
    n_checks++;
    if (oerr !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got err=%b, want 1", oerr);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, '0, '0, 3'b000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0, 35'(i + 100), 3'b000);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 2'd2, 35'(i + 200), 3'b000);
    step(1'b1, 1'b1, 2'd3, '0, 3'b000);
    n_checks++;
    if (ocount0 !== 3'd3 || ocount2 !== 3'd2 || oerr !== 1'b1) begin
      n_fail++;
      $display("FAIL premid_state: got c0=%0d c2=%0d err=%b, want 3/2/1", ocount0, ocount2, oerr);
    end
    step(1'b0, 1'b0, '0, '0, 3'b101);
    n_checks++;
    if (ovalid0 !== 1'b0 || ovalid2 !== 1'b0 || ocount0 !== '0 || ocount2 !== '0 || oerr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got v0=%b v2=%b c0=%0d c2=%0d err=%b, want all 0", ovalid0, ovalid2, ocount0, ocount2, oerr);
    end
    step(1'b1, 1'b0, '0, '0, 3'b101);
    n_checks++;
    if (ocredit !== 3'b000 || odata0 !== '0 || odata2 !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_credit: got credit=%b d0=%h d2=%h, want 000/0/0", ocredit, odata0, odata2);
    end
  endtask

  task automatic test_random();
    logic [FLIT_W-1:0] exp_d;
    logic [VCH_W-1:0]  ch;
    step(1'b0, 1'b0, '0, '0, 3'b000);
    for (int c = 0; c < 400; c++) begin
      ch = ($urandom_range(39, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
      step(($urandom_range(99, 0) != 0), ($urandom_range(2, 0) != 0), ch,
           {$urandom_range(7, 0), $urandom()}, 3'($urandom_range(7, 0)));
      for (int v = 0; v < 3; v++) begin
        exp_d = (mq[v].size() > 0) ? mq[v][0] : '0;
        n_checks++;
        if (ov[v] !== (mq[v].size() > 0) || od[v] !== exp_d || oc[v] !== 3'(mq[v].size())) begin
          n_fail++;
          $display("FAIL rand_vc%0d cyc %0d: got valid=%b data=%h count=%0d, want %b/%h/%0d",
                   v, c, ov[v], od[v], oc[v], (mq[v].size() > 0), exp_d, mq[v].size());
        end
      end
      n_checks++;
      if (ocredit !== exp_credit || oerr !== exp_err) begin
        n_fail++;
        $display("FAIL rand_flags cyc %0d: got credit=%b err=%b, want %b/%b", c, ocredit, oerr, exp_credit, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_full_enq_deq();
    test_wrap();
    test_illegal_empty();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
